// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer
//   Buffers host instructions {cmd, dir, rpt} in a small FIFO and drives them
//   to pe_array. Each instruction runs rpt+1 times. Every repetition is one
//   ready/ack handshake: ISSUE, wait for array_ready, pulse array_ack, then
//   wait for array_ready to drop again before the next repetition.
//
//   Optional build macro: PE_SEQ_PERF_EN adds saturating perf counters
//   (perf_busy_cycles, perf_acks). Without it those ports are absent.
//
// Ports
//   CLK, RST_N          clock (rising edge), async active-low reset
//   instr_valid/ready   host instruction handshake (ready = FIFO not full)
//   instr_cmd/dir/rpt   instruction payload
//   abort               synchronous flush of FIFO and current instruction
//   array_ready         completion indication from pe_array
//   array_ack           one-cycle acknowledge to pe_array
//   command_to_execute  command held to the array (0 = NOP while idle)
//   shift_direction     direction held to the array
//   busy                FSM active or FIFO non-empty
//   done_pulse          last repetition acked with nothing left queued
module pe_array_sequencer #(
  parameter int unsigned command_width = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned RPT_W         = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [command_width-1:0] instr_cmd,
  input  logic [1:0]               instr_dir,
  input  logic [RPT_W-1:0]         instr_rpt,
  input  logic                     abort,
  input  logic                     array_ready,
  output logic                     array_ack,
  output logic [command_width-1:0] command_to_execute,
  output logic [1:0]               shift_direction,
  output logic                     busy,
  output logic                     done_pulse
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_busy_cycles,
  output logic [31:0]              perf_acks
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [command_width-1:0] cmd;
    logic [1:0]               dir;
    logic [RPT_W-1:0]         rpt;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_ACK      = 3'd3,
    S_SETTLE   = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  entry_t                   r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [command_width-1:0] r_cmd;
  logic [1:0]               r_dir;
  logic [RPT_W-1:0]         r_cnt;
  logic                     r_ack;
  logic                     r_done;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_load;
  logic                     w_dec;
  logic                     w_clear;
  logic                     w_ack_nxt;
  logic                     w_done_nxt;
  entry_t                   w_head;

  // FIFO status: equal pointers = empty, only the wrap bit differs = full
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  // Ready depends only on fullness, so a same-cycle pop never frees a slot
  assign w_push  = instr_valid && !w_full && !abort;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage, no reset needed
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= entry_t'{cmd: instr_cmd, dir: instr_dir, rpt: instr_rpt};
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (!w_empty) w_state_nxt = S_ISSUE;
      S_ISSUE:    w_state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: if (array_ready) w_state_nxt = S_ACK;
      S_ACK:      w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (!array_ready) begin
          if ((r_cnt != '0) || !w_empty) w_state_nxt = S_ISSUE;
          else                           w_state_nxt = S_IDLE;
        end
      end
      default:    w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Output / datapath control decode
  always_comb begin
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_clear    = 1'b0;
    w_ack_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    if (!abort) begin
      case (r_state)
        S_IDLE: w_load = !w_empty;
        S_WAIT_RDY: begin
          if (array_ready) begin
            w_ack_nxt  = 1'b1;
            // FIFO cannot be popped here, so empty-in-ACK = empty now and no push
            w_done_nxt = (r_cnt == '0) && w_empty && !w_push;
          end
        end
        S_SETTLE: begin
          if (!array_ready) begin
            if (r_cnt != '0)   w_dec   = 1'b1;
            else if (!w_empty) w_load  = 1'b1;
            else               w_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointers, held command and registered handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cmd    <= '0;
      r_dir    <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cmd    <= '0;
      r_dir    <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_load) begin
        r_cmd <= w_head.cmd;
        r_dir <= w_head.dir;
        r_cnt <= w_head.rpt;
      end else if (w_dec) begin
        r_cnt <= r_cnt - RPT_W'(1);
      end else if (w_clear) begin
        r_cmd <= '0;
        r_dir <= '0;
      end
      r_ack  <= w_ack_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign instr_ready        = !w_full;
  assign array_ack          = r_ack;
  assign done_pulse         = r_done;
  assign command_to_execute = r_cmd;
  assign shift_direction    = r_dir;
  assign busy               = (r_state != S_IDLE) || !w_empty;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_acks;

  // Saturating activity counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_perf_busy <= '0;
      r_perf_acks <= '0;
    end else if (abort) begin
      r_perf_busy <= '0;
      r_perf_acks <= '0;
    end else begin
      if (busy && (r_perf_busy != '1))  r_perf_busy <= r_perf_busy + 32'(1);
      if (r_ack && (r_perf_acks != '1)) r_perf_acks <= r_perf_acks + 32'(1);
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_acks        = r_perf_acks;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Testbench for pe_array_sequencer: table-driven single-instruction vectors,
// directed corner sequences (FIFO fill, abort, reset in ACK, perf counters)
// and random traffic against a transaction-level expected-ack queue.
`timescale 1ns/1ps
module tb_pe_array_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_cmd = '0;
  logic [1:0] instr_dir = '0;
  logic [7:0] instr_rpt = '0;
  logic       abort = 1'b0;
  logic       array_ready = 1'b0;
  logic       array_ack;
  logic [3:0] command_to_execute;
  logic [1:0] shift_direction;
  logic       busy;
  logic       done_pulse;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_acks;
`endif

  pe_array_sequencer #(.command_width(4), .FIFO_DEPTH(4), .RPT_W(8)) dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr_cmd          (instr_cmd),
    .instr_dir          (instr_dir),
    .instr_rpt          (instr_rpt),
    .abort              (abort),
    .array_ready        (array_ready),
    .array_ack          (array_ack),
    .command_to_execute (command_to_execute),
    .shift_direction    (shift_direction),
    .busy               (busy),
    .done_pulse         (done_pulse)
`ifdef PE_SEQ_PERF_EN
    ,
    .perf_busy_cycles   (perf_busy_cycles),
    .perf_acks          (perf_acks)
`endif
  );

  always #5 CLK = ~CLK;

  // Expected (cmd, dir) for every future array_ack, in order
  typedef struct {
    logic [3:0] cmd;
    logic [1:0] dir;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int n_acks = 0;
  int n_dones = 0;
  int busy_cnt = 0;
  logic prev_ack = 1'b0;

  // Array responder state
  bit arr_en = 1'b0;
  bit rand_hold = 1'b0;
  int a_phase = 0;
  int low_cnt = 0;
  int rise_dly = 1;
  int hold_cfg = 0;
  int rel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic arr_drop();
    array_ready = 1'b0;
    low_cnt = 0;
    a_phase = 0;
    if (rand_hold) rise_dly = $urandom_range(1, 4);
  endtask

  // One cycle: sample at negedge, score acks, then advance the array model
  task automatic step();
    exp_t e;
    @(negedge CLK);
    if (busy) busy_cnt++;
    if (array_ack) begin
      n_acks++;
      chk("ack_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack_cmd", 32'(command_to_execute), 32'(e.cmd));
        chk("ack_dir", 32'(shift_direction), 32'(e.dir));
        chk("done_at_ack", 32'(done_pulse), 32'(exp_q.size() == 0));
      end
      chk("ack_one_cycle", 32'(prev_ack), 0);
    end else begin
      chk("done_without_ack", 32'(done_pulse), 0);
    end
    if (done_pulse) n_dones++;
    prev_ack = array_ack;
    if (arr_en) begin
      case (a_phase)
        0: if (busy) begin
             if (low_cnt >= rise_dly) begin array_ready = 1'b1; a_phase = 1; end
             else low_cnt++;
           end
        1: if (array_ack) begin
             rel = rand_hold ? int'($urandom_range(0, 2)) : hold_cfg;
             if (rel == 0) arr_drop();
             else a_phase = 2;
           end
        default: begin
          rel--;
          if (rel <= 0) arr_drop();
        end
      endcase
    end
  endtask

  // Drive host inputs for the coming edge and record accepted work
  task automatic set_in(input bit v, input int cmd, input int dir, input int rpt, input bit ab);
    instr_valid = v;
    instr_cmd = 4'(cmd);
    instr_dir = 2'(dir);
    instr_rpt = 8'(rpt);
    abort = ab;
    if (ab) exp_q.delete();
    else if (v && instr_ready)
      for (int i = 0; i <= rpt; i++) exp_q.push_back('{cmd: 4'(cmd), dir: 2'(dir)});
  endtask

  task automatic wait_idle(input int max_cycles, input string nm);
    for (int k = 0; k < max_cycles; k++) begin
      step();
      set_in(0, 0, 0, 0, 0);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 0);
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    set_in(0, 0, 0, 0, 0);
    array_ready = 1'b0;
    a_phase = 0;
    low_cnt = 0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    busy_cnt = 0;
    n_acks = 0;
    n_dones = 0;
    prev_ack = 1'b0;
  endtask

  typedef struct {
    int cmd;
    int dir;
    int rpt;
    int rise;
    int hold;
    int exp_acks;
    int exp_dones;
  } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{cmd: 3,  dir: 1, rpt: 0, rise: 5, hold: 0, exp_acks: 1, exp_dones: 1};
    vt[1] = '{cmd: 5,  dir: 2, rpt: 2, rise: 2, hold: 2, exp_acks: 3, exp_dones: 1};
    vt[2] = '{cmd: 15, dir: 3, rpt: 1, rise: 1, hold: 1, exp_acks: 2, exp_dones: 1};
    vt[3] = '{cmd: 0,  dir: 0, rpt: 0, rise: 3, hold: 0, exp_acks: 1, exp_dones: 1};
    vt[4] = '{cmd: 9,  dir: 1, rpt: 7, rise: 1, hold: 0, exp_acks: 8, exp_dones: 1};

    // Reset values
    RST_N = 1'b0;
    #12;
    chk("rst_instr_ready", 32'(instr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(array_ack), 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_cmd", 32'(command_to_execute), 0);
    chk("rst_dir", 32'(shift_direction), 0);
    do_reset();

    // Table: single instruction into an idle block
    arr_en = 1'b1;
    rand_hold = 1'b0;
    foreach (vt[i]) begin
      rise_dly = vt[i].rise;
      hold_cfg = vt[i].hold;
      low_cnt = 0;
      n_acks = 0;
      n_dones = 0;
      step();
      set_in(1, vt[i].cmd, vt[i].dir, vt[i].rpt, 0);
      step();
      set_in(0, 0, 0, 0, 0);
      chk("vec_t1_cmd_nop", 32'(command_to_execute), 0);
      chk("vec_t1_busy", 32'(busy), 1);
      step();
      chk("vec_t2_cmd", 32'(command_to_execute), 32'(vt[i].cmd));
      chk("vec_t2_dir", 32'(shift_direction), 32'(vt[i].dir));
      wait_idle(300, "vec");
      chk("vec_acks", 32'(n_acks), 32'(vt[i].exp_acks));
      chk("vec_dones", 32'(n_dones), 32'(vt[i].exp_dones));
      chk("vec_idle_cmd", 32'(command_to_execute), 0);
      chk("vec_idle_dir", 32'(shift_direction), 0);
    end

    // Five back-to-back pushes with the array stalled
    arr_en = 1'b0;
    array_ready = 1'b0;
    a_phase = 0;
    n_acks = 0;
    n_dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fill_ready_before_push", 32'(instr_ready), 1);
      set_in(1, i + 1, i % 4, i % 2, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fill_ready_low_when_full", 32'(instr_ready), 0);
      set_in(1, 14, 3, 0, 0);
    end
    step();
    set_in(0, 0, 0, 0, 0);
    arr_en = 1'b1;
    low_cnt = 0;
    rise_dly = 2;
    hold_cfg = 1;
    wait_idle(500, "fill");
    chk("fill_acks", 32'(n_acks), 7);
    chk("fill_dones", 32'(n_dones), 1);

    // Abort in WAIT_RDY with two entries queued and a push offered
    arr_en = 1'b0;
    array_ready = 1'b0;
    a_phase = 0;
    step(); set_in(1, 7, 2, 0, 0);
    step(); set_in(0, 0, 0, 0, 0);
    step();
    step(); set_in(1, 8, 1, 0, 0);
    step(); set_in(1, 9, 3, 0, 0);
    step();
    chk("abort_pre_busy", 32'(busy), 1);
    chk("abort_pre_cmd", 32'(command_to_execute), 7);
    set_in(1, 10, 0, 0, 1);
    n_dones = 0;
    step();
    set_in(0, 0, 0, 0, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(array_ack), 0);
    chk("abort_cmd", 32'(command_to_execute), 0);
    chk("abort_ready", 32'(instr_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_stays_idle", 32'(busy), 0);
    end
    chk("abort_no_done", 32'(n_dones), 0);

    // Reset pulled during ACK
    arr_en = 1'b1;
    rise_dly = 2;
    hold_cfg = 0;
    low_cnt = 0;
    step(); set_in(1, 12, 2, 0, 0);
    step(); set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      step();
      if (array_ack) break;
    end
    chk("rstack_reached_ack", 32'(array_ack), 1);
    RST_N = 1'b0;
    #1;
    chk("rstack_ack_async", 32'(array_ack), 0);
    chk("rstack_cmd_async", 32'(command_to_execute), 0);
    chk("rstack_busy_async", 32'(busy), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    array_ready = 1'b0;
    a_phase = 0;
    low_cnt = 0;
    exp_q.delete();
    prev_ack = 1'b0;
    #1;
    chk("rstack_ready_after", 32'(instr_ready), 1);
    step();
    chk("rstack_idle_after", 32'(busy), 0);

`ifdef PE_SEQ_PERF_EN
    // Perf counters over a rpt=2 instruction
    do_reset();
    arr_en = 1'b1;
    rise_dly = 2;
    hold_cfg = 2;
    step(); set_in(1, 4, 1, 2, 0);
    wait_idle(300, "perf");
    chk("perf_acks", perf_acks, 3);
    chk("perf_busy_cycles", perf_busy_cycles, 32'(busy_cnt));
`endif

    // Random traffic against the expected-ack queue
    do_reset();
    arr_en = 1'b1;
    rand_hold = 1'b1;
    rise_dly = 2;
    for (int c = 0; c < 1500; c++) begin
      int r;
      step();
      r = int'($urandom % 100);
      if (r < 2)       set_in(1, $urandom_range(0, 15), $urandom_range(0, 3), 0, 1);
      else if (r < 45) set_in(1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else             set_in(0, 0, 0, 0, 0);
    end
    set_in(0, 0, 0, 0, 0);
    wait_idle(4000, "rand");
    chk("rand_idle_cmd", 32'(command_to_execute), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
